// File: rtl/median_stream_ctrl_if.sv
// median_stream_ctrl_if: pixel-in / median-out stream bundle for median_stream_ctrl
//   in_valid/in_ready/in_data    : source pixel handshake (raster order)
//   out_valid/out_ready/out_data : registered median result handshake
//   frame_done                   : one-cycle pulse after the last pixel of a frame is accepted
interface median_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       frame_done;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, frame_done);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, frame_done);
endinterface

// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl: streams a raster image through a 3x3 median window with valid/ready backpressure
//   clk, rst_n (async active-low), clear (sync frame abort)
//   bus (median_stream_ctrl_if.slave): pixel input stream, median output stream, frame_done pulse
//   IMG_W, IMG_H: frame geometry (both >= 3)
//   MEDIAN_IMPULSE_ONLY_EN: when defined, the median replaces the centre only if it is 8'h00 or 8'hFF
module median_stream_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  median_stream_ctrl_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state, state_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];
  logic [8:0][7:0] win;
  logic win_valid, out_valid, frame_done;
  logic [7:0] out_data, med, result;
  logic s1_adv, s2_adv, accept, take, last_col, last_row, interior;

  // E0..E8 = win[0..8]; five bubble passes settle the five largest, leaving the median at index 4
  function automatic logic [7:0] median9(input logic [8:0][7:0] v);
    logic [7:0] t;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j];
          v[j] = v[j+1];
          v[j+1] = t;
        end
    return v[4];
  endfunction

  assign s2_adv = !out_valid || bus.out_ready;
  assign s1_adv = !win_valid || s2_adv;
  assign bus.in_ready = rst_n && s1_adv;
  assign accept = bus.in_valid && bus.in_ready;
  // clear wins over a simultaneous accept: the pixel is dropped
  assign take = accept && !clear;
  assign last_col = col == CW'(IMG_W - 1);
  assign last_row = row == RW'(IMG_H - 1);
  assign interior = row >= RW'(2) && col >= CW'(2);
  assign med = median9(win);
`ifdef MEDIAN_IMPULSE_ONLY_EN
  assign result = (win[4] == 8'h00 || win[4] == 8'hFF) ? med : win[4];
`else
  assign result = med;
`endif
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.frame_done = frame_done;

  always_comb begin
    state_d = state;
    if (take) state_d = (last_col && last_row) ? IDLE : interior ? RUN : FILL;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      win_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      win_valid <= 1'b0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      frame_done <= take && last_col && last_row;
      if (take) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= last_row ? '0 : row + 1'b1;
      end
      if (s1_adv) win_valid <= take && interior;
      if (s2_adv) begin
        out_valid <= win_valid;
        if (win_valid) out_data <= result;
      end
    end

  // storage needs no reset: every valid window is rebuilt from pixels of the current frame
  always_ff @(posedge clk)
    if (take) begin
      lb0[col] <= lb1[col];
      lb1[col] <= bus.in_data;
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb0[col];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb1[col];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= bus.in_data;
    end
endmodule

// File: tb/tb_median_stream_ctrl.sv
// tb_median_stream_ctrl: scoreboard bench for median_stream_ctrl
module tb_median_stream_ctrl;
  localparam int W = 8;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  median_stream_ctrl_if bus();
  median_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] img [H][W];
  int r = 0, c = 0, cyc = 0, n_out = 0, n_fd = 0, first_cyc = -1, acc22_cyc = -1;
  logic [7:0] first_out = 8'h00;
  logic [7:0] held = 8'h00;
  logic stalled = 1'b0;
  logic acc;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // median by rank counting: the value with at most 4 smaller and at least 5 not-larger entries
  function automatic logic [7:0] ref_med(input int rr, input int cc);
    logic [7:0] v [9];
    int lt, le;
    logic [7:0] m;
    m = 8'h00;
    for (int k = 0; k < 9; k++) v[k] = img[rr-2+k/3][cc-2+k%3];
    for (int i = 0; i < 9; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < 9; j++) begin
        if (v[j] < v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= 4 && le >= 5) m = v[i];
    end
`ifdef MEDIAN_IMPULSE_ONLY_EN
    if (!(v[4] == 8'h00 || v[4] == 8'hFF)) m = v[4];
`endif
    return m;
  endfunction

  function automatic logic [7:0] pix(input int mode, input int rr, input int cc);
    logic [7:0] a [9];
    a = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd0, 8'd7, 8'd3, 8'd6, 8'd4};
    if (mode == 2) a[4] = 8'd5;
    if (mode == 0) return 8'h55;
    if (mode == 4) return 8'($urandom_range(0, 255));
    if (rr >= 3 || cc >= 3) return 8'h20;
    if (mode == 3) return (rr == 1 && cc == 1) ? 8'hFF : 8'h10;
    return a[rr*3+cc];
  endfunction

  task automatic tick(input logic v, input logic [7:0] d, input logic rdy, input logic clr, output logic a);
    logic [7:0] e;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = rdy;
    clear = clr;
    #1;
    cyc++;
    if (bus.frame_done) n_fd++;
    if (bus.out_valid) begin
      if (stalled) check("stable", int'(bus.out_data), int'(held));
      if (first_cyc < 0) first_cyc = cyc;
      if (rdy) begin
        check("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("median", int'(bus.out_data), int'(e));
        end
        if (n_out == 0) first_out = bus.out_data;
        n_out++;
        stalled = 1'b0;
      end else begin
        held = bus.out_data;
        stalled = 1'b1;
      end
    end else stalled = 1'b0;
    a = v && bus.in_ready && rst_n;
  endtask

  task automatic send(input logic [7:0] d, input bit rnd);
    logic a;
    int t;
    t = 0;
    do begin
      tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1, d, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, a);
      t++;
    end while (!a && t < 300);
    if (!a) check("accept_timeout", int'(a), 1);
    img[r][c] = d;
    if (r >= 2 && c >= 2) exp_q.push_back(ref_med(r, c));
    if (r == 2 && c == 2) acc22_cyc = cyc;
    c++;
    if (c == W) begin
      c = 0;
      r++;
      if (r == H) r = 0;
    end
  endtask

  task automatic run_frame(input int mode, input bit rnd);
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++) send(pix(mode, rr, cc), rnd);
  endtask

  task automatic drain(input bit rnd);
    logic a;
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
      tick(1'b0, 8'h00, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, a);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic start_frame();
    n_out = 0;
    n_fd = 0;
    first_cyc = -1;
    acc22_cyc = -1;
  endtask

  task automatic to_r4c3_stalled();
    while (!(r == 4 && c == 3)) send(pix(4, r, c), 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, acc);
    tick(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("stalled_valid", int'(bus.out_valid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", int'(bus.in_ready), 1);
    start_frame();
    run_frame(0, 1'b0);
    drain(1'b0);
    check("const_count", n_out, 36);
    check("const_value", int'(first_out), 8'h55);
    check("const_latency", first_cyc - acc22_cyc, 2);
    check("const_frame_done", n_fd, 1);
    start_frame();
    run_frame(1, 1'b0);
    drain(1'b0);
    check("win_centre0", int'(first_out), 8'h04);
    start_frame();
    run_frame(2, 1'b0);
    drain(1'b0);
    check("win_centre5", int'(first_out), 8'h05);
    start_frame();
    run_frame(3, 1'b0);
    drain(1'b0);
    check("win_centreff", int'(first_out), 8'h10);
    for (int s = 0; s < 3; s++) begin
      start_frame();
      run_frame(4, 1'b1);
      drain(1'b1);
      check("rand_count", n_out, 36);
      check("rand_frame_done", n_fd, 1);
    end
    start_frame();
    run_frame(4, 1'b0);
    run_frame(4, 1'b0);
    drain(1'b0);
    check("b2b_count", n_out, 72);
    check("b2b_frame_done", n_fd, 2);
    to_r4c3_stalled();
    tick(1'b1, 8'h77, 1'b0, 1'b1, acc);
    exp_q.delete();
    r = 0;
    c = 0;
    stalled = 1'b0;
    start_frame();
    tick(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("clear_valid", int'(bus.out_valid), 0);
    run_frame(4, 1'b0);
    drain(1'b0);
    check("clear_count", n_out, 36);
    check("clear_latency", first_cyc - acc22_cyc, 2);
    to_r4c3_stalled();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bus.out_valid), 0);
    check("arst_in_ready", int'(bus.in_ready), 0);
    check("arst_out_data", int'(bus.out_data), 0);
    exp_q.delete();
    r = 0;
    c = 0;
    stalled = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    run_frame(4, 1'b0);
    drain(1'b0);
    check("arst_count", n_out, 36);
    check("arst_latency", first_cyc - acc22_cyc, 2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
